// File: rtl/ocp_reg_slave_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ocp_reg_slave_if
//  Description : OCP-lite request/response bundle between the UART transaction
//                master and the register slave.
//                  MCmd[2:0]   master -> slave  command (0 IDLE, 1 WR, 2 RD)
//                  MAddr[7:0]  master -> slave  register address
//                  MData[7:0]  master -> slave  write data
//                  SCmdAccept  slave  -> master one-cycle accept pulse
//                  SData[7:0]  slave  -> master read data (valid with SResp)
//                  SResp[1:0]  slave  -> master 0 NULL, 1 DVA, 3 ERR
//  Revision    : 1.0  initial release
// ============================================================================
interface ocp_reg_slave_if;
    logic [2:0] MCmd;
    logic [7:0] MAddr;
    logic [7:0] MData;
    logic       SCmdAccept;
    logic [7:0] SData;
    logic [1:0] SResp;

    modport master (
        output MCmd, MAddr, MData,
        input  SCmdAccept, SData, SResp
    );

    modport slave (
        input  MCmd, MAddr, MData,
        output SCmdAccept, SData, SResp
    );
endinterface
`default_nettype wire

// File: rtl/ocp_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ocp_reg_slave
//  Description : OCP-lite register slave with ID, CTRL, STATUS, scratch bank
//                and a write-only mailbox FIFO drained through a valid/ready
//                byte port. One outstanding transaction, optional accept
//                wait states.
//  Ports       : clk        system clock, rising edge
//                reset      synchronous active-high reset
//                bus        OCP-lite slave modport (MCmd/MAddr/MData in,
//                           SCmdAccept/SData/SResp out)
//                out_data   mailbox head byte
//                out_valid  mailbox non-empty and CTRL[0] set
//                out_ready  downstream consumer ready
//                ctrl_out   current CTRL value (bit7 always 0)
//  Revision    : 1.0  initial release
// ============================================================================
module ocp_reg_slave #(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter int         ACCEPT_WAIT = 0,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         NUM_SCRATCH = 4
) (
    input  wire              clk,
    input  wire              reset,
    ocp_reg_slave_if.slave   bus,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  wire              out_ready,
    output logic [7:0]       ctrl_out
);

    localparam int         c_PW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int         c_SW        = (NUM_SCRATCH > 1) ? $clog2(NUM_SCRATCH) : 1;
    localparam logic [4:0] c_DEPTH     = 5'(FIFO_DEPTH);
    localparam logic [7:0] c_SCR_BASE  = 8'h10;
    localparam logic [7:0] c_SCR_END   = 8'(16 + NUM_SCRATCH);
    localparam logic [3:0] c_WAIT_LOAD = 4'((ACCEPT_WAIT > 0) ? (ACCEPT_WAIT - 1) : 0);
    localparam logic [1:0] c_DVA       = 2'd1;
    localparam logic [1:0] c_ERR       = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_ACCEPT = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t          r_state;
    logic [2:0]      r_cmd;
    logic [7:0]      r_addr;
    logic [7:0]      r_wdata;
    logic [3:0]      r_wait_cnt;
    logic            r_accept;
    logic [7:0]      r_sdata;
    logic [1:0]      r_sresp;
    logic [6:0]      r_ctrl;
    logic            r_ovf;
    logic [7:0]      r_scratch [NUM_SCRATCH];
    logic [7:0]      r_mem     [FIFO_DEPTH];
    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [4:0]      r_count;

    logic            w_is_wr, w_is_rd, w_is_scr;
    logic            w_empty, w_full, w_pop, w_push;
    logic [c_SW-1:0] w_sidx;
    logic [7:0]      w_status;
    logic [1:0]      w_resp;
    logic [7:0]      w_rdata;
    logic            w_push_req, w_ovf_set, w_ctrl_wr, w_scr_wr;

    assign w_is_wr  = (r_cmd == 3'd1);
    assign w_is_rd  = (r_cmd == 3'd2);
    assign w_is_scr = (r_addr >= c_SCR_BASE) && (r_addr < c_SCR_END);
    assign w_sidx   = r_addr[c_SW-1:0];
    assign w_empty  = (r_count == 5'd0);
    assign w_full   = (r_count == c_DEPTH);
    assign w_status = {r_ovf, w_full, w_empty, r_count};
    assign w_pop    = out_valid && out_ready;
    assign w_push   = (r_state == S_ACCEPT) && w_push_req;

    // Decode of the latched request; only consumed while in ACCEPT.
    always_comb begin
        w_resp     = c_ERR;
        w_rdata    = 8'h00;
        w_push_req = 1'b0;
        w_ovf_set  = 1'b0;
        w_ctrl_wr  = 1'b0;
        w_scr_wr   = 1'b0;
        if (w_is_rd || w_is_wr) begin
            case (r_addr)
                8'h00: if (w_is_rd) begin
                    w_resp  = c_DVA;
                    w_rdata = ID_VALUE;
                end
                8'h01: begin
                    w_resp = c_DVA;
                    if (w_is_rd) w_rdata   = {1'b0, r_ctrl};
                    else         w_ctrl_wr = 1'b1;
                end
                8'h02: if (w_is_rd) begin
                    w_resp  = c_DVA;
                    w_rdata = w_status;
                end
                8'h03: if (w_is_wr) begin
                    // A full mailbox drops the byte even if a pop lands
                    // on the same edge.
                    if (w_full) begin
                        w_ovf_set = 1'b1;
                    end else begin
                        w_resp     = c_DVA;
                        w_push_req = 1'b1;
                    end
                end
                default: if (w_is_scr) begin
                    w_resp = c_DVA;
                    if (w_is_rd) w_rdata  = r_scratch[w_sidx];
                    else         w_scr_wr = 1'b1;
                end
            endcase
        end
    end

    // Transaction sequencer and register file.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cmd      <= 3'd0;
            r_addr     <= 8'h00;
            r_wdata    <= 8'h00;
            r_wait_cnt <= 4'd0;
            r_accept   <= 1'b0;
            r_sdata    <= 8'h00;
            r_sresp    <= 2'd0;
            r_ctrl     <= 7'd0;
            r_ovf      <= 1'b0;
            for (int i = 0; i < NUM_SCRATCH; i++) r_scratch[i] <= 8'h00;
        end else begin
            case (r_state)
                S_IDLE: if (bus.MCmd != 3'd0) begin
                    r_cmd   <= bus.MCmd;
                    r_addr  <= bus.MAddr;
                    r_wdata <= bus.MData;
                    if (ACCEPT_WAIT > 0) begin
                        r_state    <= S_WAIT;
                        r_wait_cnt <= c_WAIT_LOAD;
                    end else begin
                        r_state  <= S_ACCEPT;
                        r_accept <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (r_wait_cnt == 4'd0) begin
                        r_state  <= S_ACCEPT;
                        r_accept <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_ACCEPT: begin
                    r_accept <= 1'b0;
                    r_sresp  <= w_resp;
                    r_sdata  <= w_rdata;
                    r_state  <= S_RESP;
                    if (w_ctrl_wr) begin
                        r_ctrl <= r_wdata[6:0];
                        // Bit 7 is a write-1-to-clear strobe, never stored.
                        if (r_wdata[7]) r_ovf <= 1'b0;
                    end
                    if (w_ovf_set) r_ovf <= 1'b1;
                    if (w_scr_wr)  r_scratch[w_sidx] <= r_wdata;
                end
                S_RESP: begin
                    r_sresp <= 2'd0;
                    r_sdata <= 8'h00;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Mailbox pointers and occupancy; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= 5'd0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 5'd1;
                2'b01:   r_count <= r_count - 5'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= r_wdata;
    end

    assign out_valid      = r_ctrl[0] && !w_empty;
    assign out_data       = r_mem[r_rd_ptr];
    assign ctrl_out       = {1'b0, r_ctrl};
    assign bus.SCmdAccept = r_accept;
    assign bus.SData      = r_sdata;
    assign bus.SResp      = r_sresp;

endmodule
`default_nettype wire

// File: tb/tb_ocp_reg_slave.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ocp_reg_slave
//  Description : Self-checking bench for ocp_reg_slave. A zero-wait instance
//                gets directed and random traffic against a register/queue
//                reference model with a response scoreboard; a three-wait
//                instance covers accept latency and reset during WAIT.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ocp_reg_slave;

    localparam int AW_W = 3;

    typedef struct packed {
        logic [1:0] resp;
        logic [7:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rst_w;
    logic       out_ready, out_ready_w;
    logic [7:0] out_data, out_data_w, ctrl_out, ctrl_out_w;
    logic       out_valid, out_valid_w;

    ocp_reg_slave_if bus ();
    ocp_reg_slave_if bus_w ();

    ocp_reg_slave #(.ID_VALUE(8'hA5), .ACCEPT_WAIT(0), .FIFO_DEPTH(8), .NUM_SCRATCH(4)) u_dut (
        .clk(clk), .reset(rst), .bus(bus),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .ctrl_out(ctrl_out)
    );

    ocp_reg_slave #(.ID_VALUE(8'hA5), .ACCEPT_WAIT(AW_W), .FIFO_DEPTH(8), .NUM_SCRATCH(4)) u_dut_w (
        .clk(clk), .reset(rst_w), .bus(bus_w),
        .out_data(out_data_w), .out_valid(out_valid_w), .out_ready(out_ready_w), .ctrl_out(ctrl_out_w)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model of the zero-wait instance
    logic [6:0] m_ctrl;
    logic       m_ovf;
    logic [7:0] m_scr [4];
    logic [7:0] m_fifo [$];
    rsp_t       sb [$];
    rsp_t       sb_w [$];
    bit         rand_ready;
    bit         pop_on_accept;
    logic       prev_acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic model_reset();
        m_ctrl = 7'd0;
        m_ovf  = 1'b0;
        foreach (m_scr[i]) m_scr[i] = 8'h00;
        m_fifo.delete();
    endtask

    task automatic do_cmd(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d);
        int   n, sz;
        rsp_t e;
        bit   do_push, do_ctrl, do_scr, do_ovf;
        tick();
        bus.MCmd = c; bus.MAddr = a; bus.MData = d;
        n = 0;
        do begin tick(); n++; end while (!bus.SCmdAccept && n < 40);
        // Garbage on the bus after accept: the slave must use its latched copy.
        bus.MCmd = 3'd0; bus.MAddr = 8'($urandom); bus.MData = 8'($urandom);
        chk("accept_latency", n, 1);
        if (!bus.SCmdAccept) begin
            repeat (5) tick();
            return;
        end
        if (pop_on_accept) out_ready = 1'b1;
        // Expected outcome from the register map rules, using pre-edge state.
        e.resp = 2'd3; e.data = 8'h00;
        do_push = 0; do_ctrl = 0; do_scr = 0; do_ovf = 0;
        sz = m_fifo.size();
        if (c == 3'd1 || c == 3'd2) begin
            if (a == 8'h00) begin
                if (c == 3'd2) begin e.resp = 2'd1; e.data = 8'hA5; end
            end else if (a == 8'h01) begin
                e.resp = 2'd1;
                if (c == 3'd2) e.data = {1'b0, m_ctrl}; else do_ctrl = 1;
            end else if (a == 8'h02) begin
                if (c == 3'd2) begin
                    e.resp = 2'd1;
                    e.data = {m_ovf, sz == 8, sz == 0, 5'(sz)};
                end
            end else if (a == 8'h03) begin
                if (c == 3'd1) begin
                    if (sz >= 8) do_ovf = 1;
                    else begin e.resp = 2'd1; do_push = 1; end
                end
            end else if (a >= 8'h10 && a < 8'h14) begin
                e.resp = 2'd1;
                if (c == 3'd2) e.data = m_scr[int'(a) - 16]; else do_scr = 1;
            end
        end
        sb.push_back(e);
        tick();
        chk("accept_pulse_width", bus.SCmdAccept, 0);
        if (pop_on_accept) out_ready = 1'b0;
        // Side effects land on the edge that closed the accept cycle.
        if (do_ctrl) begin
            m_ctrl = d[6:0];
            if (d[7]) m_ovf = 1'b0;
        end
        if (do_ovf)  m_ovf = 1'b1;
        if (do_scr)  m_scr[int'(a) - 16] = d;
        if (do_push) m_fifo.push_back(d);
    endtask

    task automatic do_cmd_w(input logic [2:0] c, input logic [7:0] a, input logic [7:0] d,
                            input logic [1:0] er, input logic [7:0] ed);
        int   n;
        rsp_t e;
        tick();
        bus_w.MCmd = c; bus_w.MAddr = a; bus_w.MData = d;
        n = 0;
        do begin tick(); n++; end while (!bus_w.SCmdAccept && n < 40);
        bus_w.MCmd = 3'd0;
        chk("w_accept_latency", n, 1 + AW_W);
        e.resp = er; e.data = ed;
        if (bus_w.SCmdAccept) sb_w.push_back(e);
        tick();
        chk("w_accept_pulse_width", bus_w.SCmdAccept, 0);
    endtask

    // Response scoreboard and output-port monitor, zero-wait instance
    always @(negedge clk) begin
        rsp_t r;
        logic ev;
        if (rst) begin
            prev_acc = 1'b0;
        end else begin
            if (bus.SResp != 2'd0) begin
                chk("resp_follows_accept", prev_acc, 1);
                if (sb.size() == 0) chk("unexpected_resp", bus.SResp, 0);
                else begin
                    r = sb.pop_front();
                    chk("SResp", bus.SResp, r.resp);
                    chk("SData", bus.SData, r.data);
                end
            end
            prev_acc = bus.SCmdAccept;
            ev = m_ctrl[0] && (m_fifo.size() != 0);
            chk("out_valid", out_valid, ev);
            chk("ctrl_out", ctrl_out, {1'b0, m_ctrl});
            if (ev && out_ready) begin
                chk("out_data", out_data, m_fifo[0]);
                void'(m_fifo.pop_front());
            end
        end
    end

    // Response scoreboard, wait-state instance
    always @(negedge clk) begin
        rsp_t r;
        if (!rst_w && bus_w.SResp != 2'd0) begin
            if (sb_w.size() == 0) chk("w_unexpected_resp", bus_w.SResp, 0);
            else begin
                r = sb_w.pop_front();
                chk("w_SResp", bus_w.SResp, r.resp);
                chk("w_SData", bus_w.SData, r.data);
            end
        end
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] c;
        logic [7:0] a;
        int         sel;
        rst = 1'b1; rst_w = 1'b1;
        out_ready = 1'b0; out_ready_w = 1'b0;
        rand_ready = 0; pop_on_accept = 0;
        bus.MCmd = 3'd0; bus.MAddr = 8'h00; bus.MData = 8'h00;
        bus_w.MCmd = 3'd0; bus_w.MAddr = 8'h00; bus_w.MData = 8'h00;
        model_reset();
        repeat (3) tick();
        rst = 1'b0; rst_w = 1'b0;

        chk("rst_SCmdAccept", bus.SCmdAccept, 0);
        chk("rst_SResp", bus.SResp, 0);
        chk("rst_SData", bus.SData, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_ctrl_out", ctrl_out, 0);
        chk("rst_w_SCmdAccept", bus_w.SCmdAccept, 0);

        // ID, STATUS, scratch, unmapped, illegal command
        do_cmd(3'd2, 8'h00, 8'h00);
        do_cmd(3'd2, 8'h02, 8'h00);
        do_cmd(3'd1, 8'h11, 8'h5C);
        do_cmd(3'd2, 8'h11, 8'h00);
        do_cmd(3'd2, 8'h40, 8'h00);
        do_cmd(3'd5, 8'h01, 8'hFF);
        do_cmd(3'd2, 8'h01, 8'h00);
        do_cmd(3'd1, 8'h00, 8'h12);
        do_cmd(3'd2, 8'h03, 8'h00);

        // Fill to full with the port disabled, overflow, clear, drain
        for (int i = 0; i < 8; i++) do_cmd(3'd1, 8'h03, 8'(8'h30 + i));
        do_cmd(3'd2, 8'h02, 8'h00);
        do_cmd(3'd1, 8'h03, 8'hEE);
        do_cmd(3'd2, 8'h02, 8'h00);
        do_cmd(3'd1, 8'h01, 8'h81);
        out_ready = 1'b1;
        repeat (12) tick();
        out_ready = 1'b0;
        do_cmd(3'd2, 8'h02, 8'h00);

        // Three bytes resident, push coinciding with pop across pointer wrap
        for (int i = 0; i < 3; i++) do_cmd(3'd1, 8'h03, 8'(8'h50 + i));
        for (int i = 0; i < 9; i++) begin
            pop_on_accept = 1;
            do_cmd(3'd1, 8'h03, 8'(8'h60 + i));
            pop_on_accept = 0;
            do_cmd(3'd2, 8'h02, 8'h00);
        end
        out_ready = 1'b1;
        repeat (6) tick();
        out_ready = 1'b0;

        // Random traffic with a randomly stalling consumer
        rand_ready = 1;
        repeat (300) begin
            c   = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(1, 2)) : 3'($urandom_range(3, 7));
            sel = $urandom_range(0, 9);
            case (sel)
                0:       a = 8'h00;
                1:       a = 8'h01;
                2:       a = 8'h02;
                3, 4:    a = 8'h03;
                5, 6:    a = 8'(8'h10 + $urandom_range(0, 3));
                7:       a = 8'(8'h10 + $urandom_range(0, 15));
                8:       a = 8'($urandom);
                default: a = 8'($urandom_range(0, 7));
            endcase
            do_cmd(c, a, 8'($urandom));
        end
        rand_ready = 0;
        out_ready  = 1'b0;

        // Wait-state instance: latency, then reset during WAIT
        do_cmd_w(3'd2, 8'h00, 8'h00, 2'd1, 8'hA5);
        do_cmd_w(3'd1, 8'h03, 8'h77, 2'd1, 8'h00);
        do_cmd_w(3'd1, 8'h03, 8'h78, 2'd1, 8'h00);
        do_cmd_w(3'd1, 8'h01, 8'h05, 2'd1, 8'h00);
        do_cmd_w(3'd2, 8'h02, 8'h00, 2'd1, 8'h02);
        chk("w_ctrl_out", ctrl_out_w, 8'h05);
        chk("w_out_valid", out_valid_w, 1);
        chk("w_out_data", out_data_w, 8'h77);
        tick();
        bus_w.MCmd = 3'd2; bus_w.MAddr = 8'h00;
        tick();
        tick();
        chk("w_no_accept_in_wait", bus_w.SCmdAccept, 0);
        rst_w = 1'b1;
        bus_w.MCmd = 3'd0;
        tick();
        rst_w = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("w_abort_no_accept", bus_w.SCmdAccept, 0);
            chk("w_abort_no_resp", bus_w.SResp, 0);
        end
        chk("w_abort_ctrl_out", ctrl_out_w, 8'h00);
        chk("w_abort_out_valid", out_valid_w, 0);
        do_cmd_w(3'd2, 8'h02, 8'h00, 2'd1, 8'h20);
        do_cmd_w(3'd2, 8'h00, 8'h00, 2'd1, 8'hA5);

        repeat (5) tick();
        chk("sb_drained", sb.size(), 0);
        chk("sb_w_drained", sb_w.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ocp_reg_slave.md
Name: ocp_reg_slave

Overview:
- OCP-lite slave that sits directly downstream of the UART transaction master and consumes its MCmd/MAddr/MData requests.
- Provides an ID register, a control register, a status register, a scratch register bank and a write-only mailbox FIFO.
- The FIFO drains through a valid/ready byte port to on-chip logic.
- Single outstanding transaction, optional programmable accept wait states.

Parameters:
- ID_VALUE, 8'hA5, value returned by the ID register.
- ACCEPT_WAIT, 0, extra cycles (0..15) before SCmdAccept is asserted.
- FIFO_DEPTH, 8, mailbox depth; power of two, 2..16.
- NUM_SCRATCH, 4, number of scratch registers (1..16) at 0x10 upward.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- MCmd  in  3  command: 0 IDLE, 1 WR, 2 RD, 3-7 illegal.
- MAddr  in  8  register address.
- MData  in  8  write data.
- SCmdAccept  out  1  one-cycle accept pulse.
- SData  out  8  read data, valid while SResp != 0.
- SResp  out  2  response: 0 NULL, 1 DVA, 3 ERR.
- out_data  out  8  FIFO head byte.
- out_valid  out  1  high when FIFO is non-empty and CTRL[0]=1.
- out_ready  in  1  downstream consumer ready.
- ctrl_out  out  8  current CTRL value; bit7 reads 0.

Behaviour:
- Reset values: SCmdAccept=0, SData=0, SResp=0, CTRL=0, scratch=0, FIFO empty, overflow=0, FSM=IDLE.
- Reset mid-transaction aborts it with no response; the FIFO is flushed.
- FSM states are IDLE, WAIT, ACCEPT, RESP. All outputs are registered.
- IDLE: when MCmd != 0, latch MCmd/MAddr/MData.
  - Go to WAIT if ACCEPT_WAIT > 0, else go to ACCEPT.
- WAIT: count down ACCEPT_WAIT cycles, then go to ACCEPT.
- ACCEPT: SCmdAccept=1 for exactly one cycle.
  - Perform the side effect using the latched values.
  - Register SData/SResp, then go to RESP.
- RESP: SResp/SData are valid for exactly one cycle, then go to IDLE.
  - A new command is sampled in the cycle after RESP at the earliest.
- Latency: command first seen in cycle 0; accept in cycle 1+ACCEPT_WAIT; response in cycle 2+ACCEPT_WAIT.
- The master holds its command until accept. The block uses only the latched copy.
- Address map:
  - 0x00 ID: RO, returns ID_VALUE.
  - 0x01 CTRL: RW. Bit0 enables the out port. Bits[6:1] are storage. Bit7 write-1 clears overflow, is self-clearing, and is not stored.
  - 0x02 STATUS: RO. Bits[4:0]=FIFO count, bit5 empty, bit6 full, bit7 sticky overflow.
  - 0x03 MAILBOX: WO, a write pushes MData. A read returns ERR.
  - 0x10..0x10+NUM_SCRATCH-1: RW scratch.
- Responses:
  - Legal read or write: DVA. Write SData=0.
  - Write to an RO address: ERR, no side effect.
  - Unmapped address: ERR, SData=0.
  - Illegal MCmd (3-7): ERR, no side effect.
- FIFO write when full: byte dropped, overflow set, response ERR.
  - This applies even if a pop occurs in the same cycle.
- Push and pop in the same cycle (not full): both take effect, count unchanged.
- Pop happens when out_valid && out_ready. Read/write pointers wrap modulo FIFO_DEPTH.
- out_data shows the head entry. It is don't-care when empty.
- CTRL[0]=0 holds out_valid=0. Contents are retained.
- STATUS read in ACCEPT reflects the state before that cycle's pop.

Test Plan:
- Reset, then RD 0x00 -> SCmdAccept at cycle 1, SResp=1 and SData=0xA5 at cycle 2; RD 0x02 -> SData=0x20.
- WR 0x11=0x5C then RD 0x11 -> DVA, 0x5C; RD 0x40 -> ERR; MCmd=5 -> ERR, no register changes.
- CTRL[0]=0, write 8 bytes to 0x03 -> STATUS=0x48; 9th write -> ERR and STATUS=0xC8; WR CTRL=0x81 -> overflow clears; drain with out_ready=1 -> bytes out in order, STATUS=0x20.
- ACCEPT_WAIT=3: RD 0x00 -> SCmdAccept at cycle 4, response at cycle 5, SCmdAccept low in cycles 1-3.
- FIFO holding 3 bytes, out_ready=1, and a mailbox write accepted in the same cycle as a pop -> count stays 3, order preserved across pointer wrap.
- Assert reset during WAIT -> no SCmdAccept/SResp, FIFO empty, CTRL=0, next RD 0x00 answers normally.
